// File: rtl/readout_pkg.sv
// Shared definitions for the readout transmit/receive modules.
//   LANES / PHASE_MOD / DATA_W / PHASE_W : datapath geometry
//   rd_state_e                           : pulse FSM encoding (IDLE, PLAY, FLUSH)
//   lane_lsb()                           : bit offset of lane k in a packed lane bus
//   phase_reduce()                       : modulo-50 reduction of a sum < 150
package readout_pkg;

  localparam int unsigned LANES     = 5;
  localparam int unsigned PHASE_MOD = 50;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PHASE_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  function automatic int unsigned lane_lsb(input int unsigned k);
    return k * DATA_W;
  endfunction

  // Two conditional subtractions cover every sum the datapath forms (max 109).
  function automatic logic [PHASE_W-1:0] phase_reduce(input logic [6:0] x);
    logic [6:0] r;
    r = x;
    if (r >= 7'(PHASE_MOD)) r = r - 7'(PHASE_MOD);
    if (r >= 7'(PHASE_MOD)) r = r - 7'(PHASE_MOD);
    return PHASE_W'(r);
  endfunction

endpackage

// File: rtl/sincos_lut50.sv
// 50-point sine/cosine ROM with one register stage.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, clears the output register
//   phase_i  : phase index 0..49 (one step = 2*pi/50)
//   sincos_o : {sin_q, cos_q}, each round(32767*trig), signed 16 b, 1-cycle latency
module sincos_lut50
  import readout_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [PHASE_W-1:0]    phase_i,
  output logic [2*DATA_W-1:0]   sincos_o
);

  // Half-period tables (phase 0..25); the upper half mirrors them:
  // cos(50-p) = cos(p), sin(50-p) = -sin(p).
  localparam logic signed [DATA_W-1:0] COS_T [26] = '{
    16'sd32767,  16'sd32509,  16'sd31738,  16'sd30466,  16'sd28714,  16'sd26509,
    16'sd23886,  16'sd20886,  16'sd17557,  16'sd13952,  16'sd10126,  16'sd6140,
    16'sd2057,  -16'sd2057,  -16'sd6140,  -16'sd10126, -16'sd13952, -16'sd17557,
   -16'sd20886, -16'sd23886, -16'sd26509, -16'sd28714, -16'sd30466, -16'sd31738,
   -16'sd32509, -16'sd32767
  };
  localparam logic signed [DATA_W-1:0] SIN_T [26] = '{
    16'sd0,      16'sd4107,   16'sd8149,   16'sd12062,  16'sd15786,  16'sd19260,
    16'sd22431,  16'sd25247,  16'sd27666,  16'sd29648,  16'sd31163,  16'sd32187,
    16'sd32702,  16'sd32702,  16'sd32187,  16'sd31163,  16'sd29648,  16'sd27666,
    16'sd25247,  16'sd22431,  16'sd19260,  16'sd15786,  16'sd12062,  16'sd8149,
    16'sd4107,   16'sd0
  };

  logic [4:0]                idx;
  logic                      neg_sin;
  logic signed [DATA_W-1:0]  cos_d, sin_d;
  logic [2*DATA_W-1:0]       sincos_q;

  always_comb begin
    idx     = '0;
    neg_sin = 1'b0;
    if (phase_i <= 6'd25) begin
      idx = phase_i[4:0];
    end else begin
      idx     = 5'(6'd50 - phase_i);
      neg_sin = 1'b1;
    end
    cos_d = COS_T[idx];
    sin_d = neg_sin ? -SIN_T[idx] : SIN_T[idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sincos_q <= '0;
    else         sincos_q <= {sin_d, cos_d};
  end

  assign sincos_o = sincos_q;

endmodule

// File: rtl/readout_pulse_gen.sv
// Readout tone generator: rectangular-envelope I/Q carrier at demod_freq x 10 MHz,
// 5 lanes per 100 MHz clock (lane 0 earliest).
//   clk100, reset_n             : clock, asynchronous active-low reset
//   start                       : pulse request, honoured only in IDLE with pulse_length != 0
//   demod_freq/pulse_length/amplitude : latched on acceptance
//   dac_i/dac_q                 : 5 x 16 b signed lanes, zero when dac_valid is low
//   dac_valid/trigger_out       : sample qualifier / strobe on first valid cycle
//   busy/done                   : pulse in flight / strobe after last valid cycle
module readout_pulse_gen
  import readout_pkg::*;
(
  input  logic                     clk100,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [3:0]               demod_freq,
  input  logic [10:0]              pulse_length,
  input  logic [14:0]              amplitude,
  output logic [LANES*DATA_W-1:0]  dac_i,
  output logic [LANES*DATA_W-1:0]  dac_q,
  output logic                     dac_valid,
  output logic                     trigger_out,
  output logic                     busy,
  output logic                     done
);

  rd_state_e            state_q, state_d;
  logic [3:0]           freq_q, freq_d;
  logic [10:0]          len_q, len_d;
  logic [14:0]          amp_q, amp_d;
  logic [PHASE_W-1:0]   step_q, step_d;
  logic [PHASE_W-1:0]   base_q, base_d;
  logic [10:0]          cnt_q, cnt_d;
  logic                 issue;

  logic                 v1_q, v2_q, f1_q, f2_q;
  logic [LANES*DATA_W-1:0] dac_i_q, dac_i_d, dac_q_q, dac_q_d;

  logic [PHASE_W-1:0]   lane_ph [LANES];
  logic [2*DATA_W-1:0]  sc      [LANES];

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    len_d   = len_q;
    amp_d   = amp_q;
    step_d  = step_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (pulse_length != '0)) begin
          state_d = PLAY;
          freq_d  = demod_freq;
          len_d   = pulse_length;
          amp_d   = amplitude;
          step_d  = phase_reduce(7'(demod_freq) * 7'd5);
          base_d  = '0;
          cnt_d   = '0;
        end
      end
      PLAY: begin
        issue  = 1'b1;
        cnt_d  = cnt_q + 11'd1;
        base_d = phase_reduce(7'(base_q) + 7'(step_q));
        if (cnt_q == len_q - 11'd1) state_d = FLUSH;
      end
      FLUSH: begin
        if (!v1_q && !v2_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      freq_q  <= '0;
      len_q   <= '0;
      amp_q   <= '0;
      step_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      len_q   <= len_d;
      amp_q   <= amp_d;
      step_q  <= step_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------- stage 0: lane phases ----------------
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_ph[k] = phase_reduce(7'(base_q) + 7'(k) * 7'(freq_q));
    end
  end

  // ---------------- stage 1: per-lane ROM ----------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sincos_lut50 u_lut (
      .clk_i    (clk100),
      .rst_ni   (reset_n),
      .phase_i  (lane_ph[k]),
      .sincos_o (sc[k])
    );
  end

  // ---------------- stage 2: envelope scaling ----------------
  logic signed [DATA_W-1:0] cos_s, sin_s;
  logic signed [31:0]       amp_s, prod_i, prod_q;

  assign amp_s = 32'(amp_q);

  always_comb begin
    dac_i_d = '0;
    dac_q_d = '0;
    cos_s   = '0;
    sin_s   = '0;
    prod_i  = '0;
    prod_q  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      cos_s  = sc[k][DATA_W-1:0];
      sin_s  = sc[k][2*DATA_W-1:DATA_W];
      prod_i = 32'(cos_s) * amp_s;
      prod_q = 32'(sin_s) * amp_s;
      if (v1_q) begin
        dac_i_d[lane_lsb(k) +: DATA_W] = DATA_W'(prod_i >>> 15);
        dac_q_d[lane_lsb(k) +: DATA_W] = DATA_W'(prod_q >>> 15);
      end
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      dac_i_q <= '0;
      dac_q_q <= '0;
    end else begin
      v1_q    <= issue;
      f1_q    <= issue && (cnt_q == '0);
      v2_q    <= v1_q;
      f2_q    <= f1_q;
      dac_i_q <= dac_i_d;
      dac_q_q <= dac_q_d;
    end
  end

  assign dac_i       = dac_i_q;
  assign dac_q       = dac_q_q;
  assign dac_valid   = v2_q;
  assign trigger_out = f2_q;

endmodule
